// File: rtl/iob_skid_buf_pkg.sv
// iob_skid_buf shared definitions: default parameters
// and the control state encoding.
package iob_skid_buf_pkg;

  localparam int IOB_SKID_BUF_DATA_W  = 32;
  localparam int IOB_SKID_BUF_RST_VAL = 0;
  localparam int IOB_SKID_BUF_ST_W    = 2;

  typedef enum logic [IOB_SKID_BUF_ST_W-1:0] {
    IOB_SKID_BUF_EMPTY = 2'd0,
    IOB_SKID_BUF_ONE   = 2'd1,
    IOB_SKID_BUF_FULL  = 2'd2
  } iob_skid_buf_st_t;

endpackage

// File: rtl/iob_reg_r.sv
// iob_reg_r: register with synchronous reset
// (reset wins over enable) and load enable.
module iob_reg_r #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // reset to RST_VAL, otherwise load when enabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/iob_skid_buf.sv
// iob_skid_buf: two-entry registered valid/ready skid stage.
// Optional occupancy port via IOB_SKID_BUF_LEVEL_EN.
module iob_skid_buf
  import iob_skid_buf_pkg::*;
#(
  parameter int                DATA_W  = IOB_SKID_BUF_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL =
    DATA_W'(IOB_SKID_BUF_RST_VAL)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cke_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i
`ifdef IOB_SKID_BUF_LEVEL_EN
  ,
  output logic [1:0]        level_o
`endif
);

  iob_skid_buf_st_t st_q;
  iob_skid_buf_st_t st_d;

  logic              s_ready_q;
  logic              m_valid_q;
  logic              clr;
  logic              xfer_in;
  logic              xfer_out;
  logic              main_en;
  logic              skid_en;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  assign clr      = ~rst_n_i | flush_i;
  assign xfer_in  = cke_i & s_valid_i & s_ready_q;
  assign xfer_out = cke_i & m_valid_q & m_ready_i;

  // next state and data-register load controls
  always_comb begin
    st_d    = st_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = s_data_i;
    case (st_q)
      IOB_SKID_BUF_EMPTY: begin
        if (xfer_in) begin
          st_d    = IOB_SKID_BUF_ONE;
          main_en = 1'b1;
        end
      end
      IOB_SKID_BUF_ONE: begin
        case ({xfer_in, xfer_out})
          2'b11: main_en = 1'b1;
          2'b10: begin
            st_d    = IOB_SKID_BUF_FULL;
            skid_en = 1'b1;
          end
          2'b01: st_d = IOB_SKID_BUF_EMPTY;
          default: ;
        endcase
      end
      IOB_SKID_BUF_FULL: begin
        if (xfer_out) begin
          st_d    = IOB_SKID_BUF_ONE;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: begin
        if (cke_i) begin
          st_d = IOB_SKID_BUF_EMPTY;
        end
      end
    endcase
  end

  // state plus pre-decoded ready/valid flops
  always_ff @(posedge clk_i) begin
    if (clr) begin
      st_q      <= IOB_SKID_BUF_EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      s_ready_q <= (st_d != IOB_SKID_BUF_FULL);
      m_valid_q <= (st_d != IOB_SKID_BUF_EMPTY);
    end
  end

  iob_reg_r #(
    .W       (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk_i (clk_i),
    .rst_i (clr),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  iob_reg_r #(
    .W       (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk_i (clk_i),
    .rst_i (clr),
    .en_i  (skid_en),
    .d_i   (s_data_i),
    .q_o   (skid_q)
  );

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = main_q;

`ifdef IOB_SKID_BUF_LEVEL_EN
  logic [1:0] level_q;

  // occupancy mirror of the state register
  always_ff @(posedge clk_i) begin
    if (clr) begin
      level_q <= 2'd0;
    end else begin
      level_q <= st_d;
    end
  end

  assign level_o = level_q;
`endif

endmodule

// File: tb/tb_iob_skid_buf.sv
// tb_iob_skid_buf: directed scenarios plus random traffic
// checked every cycle against a queue-based model.
module tb_iob_skid_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cke = 1'b1;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready_o;
  logic       m_valid_o;
  logic [7:0] m_data_o;
  logic       m_ready = 1'b0;
`ifdef IOB_SKID_BUF_LEVEL_EN
  logic [1:0] level_o;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  iob_skid_buf #(
    .DATA_W  (8),
    .RST_VAL (8'hA5)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .cke_i     (cke),
    .flush_i   (flush),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .s_ready_o (s_ready_o),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_ready_i (m_ready)
`ifdef IOB_SKID_BUF_LEVEL_EN
    ,
    .level_o   (level_o)
`endif
  );

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  // model: the buffer is just a FIFO of at most 2 words
  logic [7:0] mq[$];
  logic [7:0] last_out = 8'hA5;
  bit         m_in;
  bit         m_out;

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      mq.delete();
      last_out = 8'hA5;
    end else if (cke) begin
      m_in  = s_valid && (mq.size() < 2);
      m_out = m_ready && (mq.size() > 0);
      if (m_out) last_out = mq.pop_front();
      if (m_in) mq.push_back(s_data);
    end
  end

  // words the DUT hands downstream
  logic [7:0] out_log[$];

  always @(posedge clk) begin
    if (rst_n && !flush && cke && m_valid_o && m_ready)
      out_log.push_back(m_data_o);
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("s_ready", {31'd0, s_ready_o},
          {31'd0, mq.size() < 2});
      chk("m_valid", {31'd0, m_valid_o},
          {31'd0, mq.size() > 0});
      chk("m_data", {24'd0, m_data_o},
          {24'd0, (mq.size() > 0) ? mq[0] : last_out});
`ifdef IOB_SKID_BUF_LEVEL_EN
      chk("level", {30'd0, level_o}, mq.size());
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d,
                      input string nm);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      done = s_ready_o && cke && !flush && rst_n;
      step();
    end
    s_valid = 1'b0;
    chk({nm, "_accept"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_log(input string nm,
                           input logic [7:0] exp[$]);
    chk({nm, "_count"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < out_log.size())
        chk({nm, "_word"}, {24'd0, out_log[i]},
            {24'd0, exp[i]});
    end
  endtask

  logic [7:0] exp_q[$];

  initial begin
    // reset
    rst_n = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_s_ready", {31'd0, s_ready_o}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_m_data", {24'd0, m_data_o}, 32'hA5);
    rst_n = 1'b1;
    step();

    // back-to-back stream
    out_log.delete();
    exp_q.delete();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      exp_q.push_back(8'(i));
      step();
    end
    s_valid = 1'b0;
    step();
    check_log("stream", exp_q);

    // backpressure
    out_log.delete();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h11;
    step();
    s_data = 8'h22;
    step();
    s_data = 8'h33;
    step();
    chk("bp_s_ready", {31'd0, s_ready_o}, 32'd0);
    chk("bp_m_data", {24'd0, m_data_o}, 32'h11);
    m_ready = 1'b1;
    push(8'h33, "bp_33");
    step();
    step();
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_log("bp", exp_q);

    // simultaneous in/out while holding one word
    out_log.delete();
    m_ready = 1'b0;
    push(8'h44, "sim_44");
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    s_valid = 1'b0;
    chk("sim_m_data", {24'd0, m_data_o}, 32'h55);
    chk("sim_m_valid", {31'd0, m_valid_o}, 32'd1);
    chk("sim_s_ready", {31'd0, s_ready_o}, 32'd1);
    step();
    exp_q = '{8'h44, 8'h55};
    check_log("sim", exp_q);

    // flush while full
    m_ready = 1'b0;
    push(8'h66, "fl_66");
    push(8'h77, "fl_77");
    out_log.delete();
    s_valid = 1'b1;
    s_data  = 8'h88;
    m_ready = 1'b1;
    flush   = 1'b1;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("fl_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("fl_s_ready", {31'd0, s_ready_o}, 32'd1);
    chk("fl_m_data", {24'd0, m_data_o}, 32'hA5);
    step();
    step();
    chk("fl_emitted", out_log.size(), 32'd0);

    // clock enable low mid-stream
    m_ready = 1'b0;
    push(8'h90, "ck_90");
    out_log.delete();
    cke     = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h91;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ck_m_valid", {31'd0, m_valid_o}, 32'd1);
      chk("ck_m_data", {24'd0, m_data_o}, 32'h90);
      chk("ck_s_ready", {31'd0, s_ready_o}, 32'd1);
    end
    chk("ck_frozen", out_log.size(), 32'd0);
    cke = 1'b1;
    push(8'h91, "ck_91");
    step();
    step();
    exp_q = '{8'h90, 8'h91};
    check_log("ck", exp_q);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s_valid = 1'($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 2) != 0);
      cke     = 1'($urandom_range(0, 9) != 0);
      flush   = 1'($urandom_range(0, 49) == 0);
      rst_n   = 1'($urandom_range(0, 99) != 0);
      step();
    end
    rst_n   = 1'b1;
    flush   = 1'b0;
    cke     = 1'b1;
    s_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
